logic_op_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit continuous-assignment AND gate.
- Performs a selectable bitwise operation (AND/OR/XOR/NAND) on two WIDTH-bit operands.
- Results pass through STAGES registered pipeline stages with valid/ready flow control.
- Keeps a saturating count of completed operations; used as a reusable datapath primitive between handshaked blocks.

---
 rtl/logic_op_pipe.sv | 137 +++++++++++++
 tb/tb_logic_op_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// -----------------------------------------------------------------------------
// logic_op_pipe
// Pipelined bitwise operator (AND / OR / XOR / NAND) on two WIDTH-bit operands.
// The result travels through STAGES register stages under valid/ready flow
// control. Bubbles compress, and one transfer per cycle is sustained.
// A saturating counter records how many results downstream has accepted.
//
// Optional build macro: LOGIC_OP_PARITY_EN
//   When it is defined, the block adds the output out_parity. This is the
//   XOR-reduction of the result, and it is carried through the pipeline
//   alongside out.
// -----------------------------------------------------------------------------
module logic_op_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
`ifdef LOGIC_OP_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    // Bitwise operation selected by op; NAND inverts every result bit.
    function automatic logic [WIDTH-1:0] f_logic_op(
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v,
        input logic [1:0]       op_v
    );
        logic [WIDTH-1:0] res;
        case (op_v)
            2'b00:   res = a_v & b_v;
            2'b01:   res = a_v | b_v;
            2'b10:   res = a_v ^ b_v;
            2'b11:   res = ~(a_v & b_v);
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Even-parity bit of a result word.
    function automatic logic f_parity(input logic [WIDTH-1:0] d_v);
        return ^d_v;
    endfunction

    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0]            r_valid;
    logic [CNT_W-1:0]             r_count;
    logic [STAGES-1:0]            w_adv;
    logic                         w_out_xfer;

    // Ready chain: a stage may advance if out_ready is high or if it, or any
    // stage after it, is empty. This lets bubbles compress toward the output.
    always_comb begin
        logic v_full;
        v_full = 1'b1;
        w_adv  = {STAGES{1'b0}};
        for (int i = STAGES - 1; i >= 0; i--) begin
            v_full   = v_full & r_valid[i];
            w_adv[i] = out_ready | ~v_full;
        end
    end

    assign in_ready   = w_adv[0];
    assign w_out_xfer = r_valid[STAGES-1] & out_ready;

    // Pipeline registers: stage 0 captures the operation result, and each
    // later stage copies its predecessor whenever that stage may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= {STAGES{1'b0}};
            r_data  <= {(STAGES*WIDTH){1'b0}};
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= f_logic_op(a, b, op);
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end
    end

    // Saturating count of results accepted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_out_xfer && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out       = r_data[STAGES-1];
    assign op_count  = r_count;
    assign busy      = |r_valid;

`ifdef LOGIC_OP_PARITY_EN
    logic [STAGES-1:0] r_par;

    // Parity shadow pipeline. It advances in lockstep with r_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= {STAGES{1'b0}};
        end else begin
            if (w_adv[0] && in_valid) begin
                r_par[0] <= f_parity(f_logic_op(a, b, op));
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_par[i] <= r_par[i-1];
                end
            end
        end
    end

    assign out_parity = r_par[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard testbench for logic_op_pipe.
// The driver issues transactions. A negedge monitor pushes the expected result
// at each input transfer, then pops and compares it at each output transfer.
module tb_logic_op_pipe;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int CW = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] a, b, out;
    logic [1:0]   op;
    logic [CW-1:0] op_count;
`ifdef LOGIC_OP_PARITY_EN
    logic         out_parity;
`endif

    // Second instance: single stage, 2-bit counter for saturation/boundary.
    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [W-1:0] s_a, s_b, s_out;
    logic [1:0]   s_op;
    logic [1:0]   s_op_count;
`ifdef LOGIC_OP_PARITY_EN
    logic         s_out_parity;
`endif

    logic_op_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .op_count(op_count), .busy(busy)
`ifdef LOGIC_OP_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    logic_op_pipe #(.WIDTH(W), .STAGES(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out(s_out), .op_count(s_op_count), .busy(s_busy)
`ifdef LOGIC_OP_PARITY_EN
        , .out_parity(s_out_parity)
`endif
    );

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [W-1:0] exp_q[$];
    int           in_log[$];
    int           out_log[$];
    longint       exp_cnt = 0;
    bit           rdy_mode = 1'b0;
    bit           rdy_val  = 1'b1;
    localparam longint CNT_MAX = (64'd1 << CW) - 64'd1;

    // Reference model: each op is a 2-input truth table applied bit by bit.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic [1:0] ov);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (ov)
            2'd0:    tt = 4'b1000;
            2'd1:    tt = 4'b1110;
            2'd2:    tt = 4'b0110;
            default: tt = 4'b0111;
        endcase
        for (int k = 0; k < W; k++) r[k] = tt[{av[k], bv[k]}];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // out_ready driver: either a held value or random back-pressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        logic [W-1:0] e;
        @(negedge clk);
        if (rst_n) begin
            check("busy", busy, exp_q.size() != 0);
            check("in_ready", in_ready, out_ready || (exp_q.size() < S));
            check("op_count", op_count, exp_cnt);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(a, b, op));
                in_log.push_back(cyc + 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("out", out, e);
`ifdef LOGIC_OP_PARITY_EN
                    check("out_parity", out_parity, ^e);
`endif
                    out_log.push_back(cyc + 1);
                    if (exp_cnt < CNT_MAX) exp_cnt++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] ov);
        bit acc = 1'b0;
        int n   = 0;
        a = av; b = bv; op = ov; in_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 2'd0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_op = 2'd0; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        check("rst_sat_count", s_op_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: four ops on F0/3C back to back, then the parity vector.
        in_log.delete(); out_log.delete();
        send(8'hF0, 8'h3C, 2'b00);
        send(8'hF0, 8'h3C, 2'b01);
        send(8'hF0, 8'h3C, 2'b10);
        send(8'hF0, 8'h3C, 2'b11);
        drain();
        check("t1_n_out", out_log.size(), 4);
        if (out_log.size() == 4 && in_log.size() == 4) begin
            check("t1_latency", out_log[0] - in_log[0], S);
            check("t1_consecutive", out_log[3] - out_log[0], 3);
        end
        check("t1_op_count", op_count, 4);
        send(8'h07, 8'h00, 2'b01);
        drain();

        // 2: back-pressure with three transfers.
        rdy_val = 1'b0;
        in_log.delete(); out_log.delete();
        send(8'h01, 8'hFF, 2'b00);
        send(8'h02, 8'hFF, 2'b00);
        a = 8'h03; b = 8'hFF; op = 2'b00; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_hold", out, 8'h01);
            @(posedge clk);
            #1;
        end
        rdy_val = 1'b1;
        send(8'h03, 8'hFF, 2'b00);
        drain();
        check("bp_n_out", out_log.size(), 3);

        // 3: full throughput with simultaneous accept and output.
        in_log.delete(); out_log.delete();
        for (int k = 0; k < 10; k++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        drain();
        if (in_log.size() == 10 && out_log.size() == 10) begin
            check("thr_in", in_log[9] - in_log[0], 9);
            check("thr_out", out_log[9] - out_log[0], 9);
        end else begin
            check("thr_count", out_log.size(), 10);
        end

        // 4: asynchronous reset with two results in flight.
        rdy_val = 1'b0;
        send(8'h55, 8'hAA, 2'b01);
        send(8'h0F, 8'h33, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out", out, 0);
        check("ar_op_count", op_count, 0);
        check("ar_busy", busy, 0);
        exp_q.delete();
        exp_cnt = 0;
        #1 rst_n = 1'b1;
        #1;
        check("ar_in_ready", in_ready, 1);
        rdy_val = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("ar_no_stale", out_valid, 0);

        // 5: random traffic under random back-pressure.
        rdy_mode = 1'b1;
        repeat (150) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
        drain();

        // 6: STAGES=1, CNT_W=2 saturation: counts 0,1,2,3,3,3.
        for (int k = 1; k <= 6; k++) begin
            s_in_valid = (k <= 5);
            s_a = 8'(k); s_b = 8'hF0; s_op = 2'b10;
            @(posedge clk);
            @(negedge clk);
            check("sat_count", s_op_count, (k - 1 > 3) ? 3 : k - 1);
            check("sat_out_valid", s_out_valid, k <= 5);
            if (k <= 5) check("sat_out", s_out, ref_op(8'(k), 8'hF0, 2'b10));
            check("sat_in_ready", s_in_ready, 1);
            #1;
        end
        s_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
